// File: rtl/vector_list_seq.sv
// rtl/vector_list_seq.sv - vector-shape ROM sequencer feeding the line-draw engine
// Walks the ROM from addr 0, offsets and clamps each point, and issues it over valid/ready.
module vector_list_seq #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 18,
  parameter int LAST_ADDR    = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              x_off,
  input  logic [7:0]              y_off,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_x,
  output logic [7:0]              out_y,
  output logic                    out_draw,
  output logic                    out_move,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [ADDRESSWIDTH-1:0] LAST = ADDRESSWIDTH'(LAST_ADDR);

  state_t     state;
  logic [7:0] x_lat;
  logic [7:0] y_lat;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic [7:0] clamp_x;
  logic [7:0] clamp_y;
  logic       word_draw;
  logic       word_move;

  always_comb begin
    sum_x     = {1'b0, rom_data[DATAWIDTH-1 -: 8]} + {1'b0, x_lat};
    sum_y     = {1'b0, rom_data[DATAWIDTH-9 -: 8]} + {1'b0, y_lat};
    clamp_x   = sum_x[8] ? 8'hFF : sum_x[7:0];
    clamp_y   = sum_y[8] ? 8'hFF : sum_y[7:0];
    word_draw = rom_data[1];
    word_move = rom_data[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_x     <= 8'd0;
      out_y     <= 8'd0;
      out_draw  <= 1'b0;
      out_move  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_lat     <= 8'd0;
      y_lat     <= 8'd0;
    end else if (abort) begin
      // Abort beats start and any same-cycle handshake; the pending point is dropped.
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_lat    <= x_off;
            y_lat    <= y_off;
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!word_draw && !word_move) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_x     <= clamp_x;
            out_y     <= clamp_y;
            out_draw  <= word_draw;
            out_move  <= word_move & ~word_draw;
            out_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (rom_addr == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_list_seq.sv
// tb/tb_vector_list_seq.sv - table-driven bench for vector_list_seq
module tb_vector_list_seq;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       d;
    logic       m;
  } pt_t;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rd;
    logic       rm;
    logic [7:0] ex;
    logic [7:0] ey;
    logic       ed;
    logic       em;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [7:0]  x_off, y_off;
  logic [3:0]  rom_addr;
  logic [17:0] rom_data;
  logic        out_valid, out_draw, out_move, busy, done;
  logic [7:0]  out_x, out_y;

  logic [17:0] rom_mem [16];
  logic        term_en;
  logic [3:0]  term_addr;
  vec_t        tbl [15];
  pt_t         pts [$];
  pt_t         cur;
  int          n_chk = 0;
  int          n_fail = 0;

  vector_list_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_off(x_off), .y_off(y_off), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_draw(out_draw), .out_move(out_move), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_data = rom_mem[rom_addr];
    if (term_en && rom_addr == term_addr) rom_data = 18'd0;
  end

  assign cur = {out_x, out_y, out_draw, out_move};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pt_t tbl_pt(input int k);
    return {tbl[k].ex, tbl[k].ey, tbl[k].ed, tbl[k].em};
  endfunction

  function automatic pt_t model_pt(input int k, input logic [7:0] xo, input logic [7:0] yo);
    int sx, sy;
    sx = int'(tbl[k].rx) + int'(xo);
    sy = int'(tbl[k].ry) + int'(yo);
    if (sx > 255) sx = 255;
    if (sy > 255) sy = 255;
    return {8'(sx), 8'(sy), tbl[k].ed, tbl[k].em};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_x"}, out_x, 0);
    chk({tag, "_y"}, out_y, 0);
    chk({tag, "_draw"}, out_draw, 0);
    chk({tag, "_move"}, out_move, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic start_list(input logic [7:0] xo, input logic [7:0] yo);
    tick;
    x_off = xo;
    y_off = yo;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Runs the list after the start edge; returns edges until done and the edge of first valid.
  task automatic play(input int stall_idx, input int stall_len, input int abort_idx,
                      input int start_idx, input int max_cyc,
                      output int cyc, output bit got_done, output int first_valid);
    int  sc;
    bit  stop;
    cyc = 0; got_done = 0; sc = 0; stop = 0; first_valid = -1;
    pts.delete();
    while (!stop) begin
      start = 1'b0;
      out_ready = 1'b1;
      if (done) begin
        got_done = 1;
        stop = 1;
      end else if (cyc >= max_cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL play_timeout: got %0d cycles without done", cyc);
        stop = 1;
      end else begin
        if (out_valid) begin
          if (first_valid < 0) first_valid = cyc;
          chk("no_valid_at_term", {31'd0, term_en && rom_addr == term_addr}, 0);
          if (pts.size() == abort_idx) begin
            abort = 1'b1;
          end else if (pts.size() == stall_idx && sc < stall_len) begin
            out_ready = 1'b0;
            chk("stall_hold", cur, tbl_pt(stall_idx));
            sc++;
          end else begin
            pts.push_back(cur);
            if (pts.size() - 1 == start_idx) start = 1'b1;
          end
        end
        tick;
        cyc++;
        if (abort) begin
          abort = 1'b0;
          stop = 1;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic check_pts(input string tag, input int n_exp, input logic [7:0] xo, input logic [7:0] yo);
    chk({tag, "_count"}, pts.size(), n_exp);
    for (int k = 0; k < n_exp && k < pts.size(); k++)
      chk($sformatf("%s_pt%0d", tag, k), pts[k], model_pt(k, xo, yo));
  endtask

  initial begin
    int cyc, fv;
    bit gd;

    // {rom x, rom y, draw, move, expected x, y, draw, move} with zero offsets
    tbl[0]  = '{174, 162, 0, 1, 174, 162, 0, 1};
    tbl[1]  = '{120,  80, 1, 0, 120,  80, 1, 0};
    tbl[2]  = '{200,  40, 1, 0, 200,  40, 1, 0};
    tbl[3]  = '{ 92, 148, 0, 1,  92, 148, 0, 1};
    tbl[4]  = '{ 10,  20, 1, 1,  10,  20, 1, 0};
    tbl[5]  = '{ 60,  70, 1, 0,  60,  70, 1, 0};
    tbl[6]  = '{ 80,  90, 0, 1,  80,  90, 0, 1};
    tbl[7]  = '{100, 110, 1, 0, 100, 110, 1, 0};
    tbl[8]  = '{130, 140, 1, 0, 130, 140, 1, 0};
    tbl[9]  = '{150, 160, 0, 1, 150, 160, 0, 1};
    tbl[10] = '{170, 180, 1, 0, 170, 180, 1, 0};
    tbl[11] = '{190, 200, 1, 0, 190, 200, 1, 0};
    tbl[12] = '{210, 220, 0, 1, 210, 220, 0, 1};
    tbl[13] = '{230, 240, 1, 0, 230, 240, 1, 0};
    tbl[14] = '{ 54, 105, 1, 0,  54, 105, 1, 0};
    for (int k = 0; k < 15; k++) rom_mem[k] = {tbl[k].rx, tbl[k].ry, tbl[k].rd, tbl[k].rm};
    rom_mem[15] = 18'd0;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    x_off = 8'd0; y_off = 8'd0; term_en = 1'b0; term_addr = 4'd0;
    tick;
    tick;
    chk_reset("reset");
    rst_n = 1'b1;
    tick;

    // Full list, ready high, zero offsets
    start_list(8'd0, 8'd0);
    chk("fetch_busy", busy, 1);
    chk("fetch_valid", out_valid, 0);
    play(-1, 0, -1, -1, 200, cyc, gd, fv);
    chk("full_done", gd, 1);
    chk("full_cycles", cyc, 30);
    chk("full_latency", fv, 1);
    check_pts("full", 15, 8'd0, 8'd0);
    chk("full_busy_at_done", busy, 0);
    chk("full_addr_hold", rom_addr, 14);
    tick;
    chk("done_pulse_width", done, 0);

    // Backpressure on point 3
    start_list(8'd0, 8'd0);
    play(3, 5, -1, -1, 200, cyc, gd, fv);
    chk("bp_done", gd, 1);
    chk("bp_cycles", cyc, 35);
    check_pts("bp", 15, 8'd0, 8'd0);

    // Clamp
    start_list(8'd100, 8'd0);
    play(-1, 0, -1, -1, 200, cyc, gd, fv);
    chk("clamp_done", gd, 1);
    check_pts("clamp", 15, 8'd100, 8'd0);
    if (pts.size() > 3) begin
      chk("clamp_pt0_x", pts[0].x, 255);
      chk("clamp_pt3_x", pts[3].x, 192);
    end

    // Terminator word at addr 5
    term_en = 1'b1;
    term_addr = 4'd5;
    start_list(8'd0, 8'd0);
    play(-1, 0, -1, -1, 200, cyc, gd, fv);
    chk("term_done", gd, 1);
    chk("term_cycles", cyc, 11);
    check_pts("term", 5, 8'd0, 8'd0);
    term_en = 1'b0;

    // Abort in ISSUE of point 7 with ready high
    start_list(8'd0, 8'd0);
    play(-1, 0, 7, -1, 200, cyc, gd, fv);
    chk("abort_no_done", gd, 0);
    chk("abort_count", pts.size(), 7);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_idle_done", done, 0);
      chk("abort_idle_valid", out_valid, 0);
    end
    start_list(8'd0, 8'd0);
    play(-1, 0, -1, -1, 200, cyc, gd, fv);
    chk("replay_done", gd, 1);
    chk("replay_cycles", cyc, 30);
    check_pts("replay", 15, 8'd0, 8'd0);

    // start while busy is ignored
    start_list(8'd0, 8'd0);
    play(-1, 0, -1, 4, 200, cyc, gd, fv);
    chk("busy_start_done", gd, 1);
    chk("busy_start_cycles", cyc, 30);
    check_pts("busy_start", 15, 8'd0, 8'd0);

    // Reset mid-list
    start_list(8'd20, 8'd30);
    for (int i = 0; i < 5; i++) tick;
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    tick;
    chk_reset("midrst");
    rst_n = 1'b1;
    tick;
    chk("midrst_idle_valid", out_valid, 0);
    chk("midrst_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
